// File: rtl/program_loader_if.sv
// ---------------------------------------------------------------------------
// program_loader_if
//   Byte-stream input and program-memory write port of the program loader.
//   Signal names are given from the loader's point of view.
//
//   i_rx_data    : received byte, valid only while i_rx_valid is high
//   i_rx_valid   : one-cycle strobe, one byte per strobe
//   o_wr_address : program memory write address
//   o_wr_data    : program memory write data
//   o_wr_enb     : program memory write strobe, one cycle per word
//
//   Modports:
//     slave  - the loader: consumes the byte stream, drives the write port
//     master - the environment: drives the byte stream, observes the writes
// ---------------------------------------------------------------------------
interface program_loader_if #(
    parameter int NB_INSTRUCTION = 16,
    parameter int NB_ADDR        = 11,
    parameter int NB_BYTE        = 8
);
    logic [NB_BYTE-1:0]        i_rx_data;
    logic                      i_rx_valid;
    logic [NB_ADDR-1:0]        o_wr_address;
    logic [NB_INSTRUCTION-1:0] o_wr_data;
    logic                      o_wr_enb;

    modport slave (
        input  i_rx_data,
        input  i_rx_valid,
        output o_wr_address,
        output o_wr_data,
        output o_wr_enb
    );

    modport master (
        output i_rx_data,
        output i_rx_valid,
        input  o_wr_address,
        input  o_wr_data,
        input  o_wr_enb
    );
endinterface

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//   Fills instruction memory from a byte stream. Bytes are paired high byte
//   first into NB_INSTRUCTION-bit words, written to consecutive addresses
//   starting at 0. The CPU is held in reset until a HALT word (opcode 0) has
//   been written. Filling the last address without a HALT is an error.
//
//   Ports:
//     i_clock     : system clock, rising edge
//     i_reset     : synchronous active-high reset
//     i_load_req  : one-cycle pulse, restarts a load from DONE or ERROR
//     io_bus      : byte stream in / program memory write port (slave side)
//     o_cpu_reset : high while loading, releases the CPU after HALT
//     o_load_done : high while in DONE
//     o_error     : high while in ERROR (memory full without HALT)
// ---------------------------------------------------------------------------
module program_loader #(
    parameter int NB_INSTRUCTION = 16,
    parameter int NB_ADDR        = 11,
    parameter int NB_OPCODE      = 5,
    parameter int NB_BYTE        = 8
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_load_req,
    program_loader_if.slave         io_bus,
    output logic                    o_cpu_reset,
    output logic                    o_load_done,
    output logic                    o_error
);

    localparam logic [NB_ADDR-1:0] ADDR_LAST = {NB_ADDR{1'b1}};

    typedef enum logic [2:0] {
        S_WAIT_HI,
        S_WAIT_LO,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                    r_state;
    logic [NB_ADDR-1:0]        r_addr;
    logic [NB_BYTE-1:0]        r_hi;
    logic [NB_ADDR-1:0]        r_wr_address;
    logic [NB_INSTRUCTION-1:0] r_wr_data;
    logic                      r_wr_enb;
    logic                      r_cpu_reset;
    logic                      r_load_done;
    logic                      r_error;

    state_t                    w_state_nxt;
    logic [NB_ADDR-1:0]        w_addr_nxt;
    logic [NB_BYTE-1:0]        w_hi_nxt;
    logic [NB_ADDR-1:0]        w_wr_address_nxt;
    logic [NB_INSTRUCTION-1:0] w_wr_data_nxt;
    logic                      w_wr_enb_nxt;
    logic                      w_cpu_reset_nxt;
    logic                      w_load_done_nxt;
    logic                      w_error_nxt;
    logic                      w_is_halt;

    // The word being written this cycle is the one held on the write port.
    assign w_is_halt = (r_wr_data[NB_INSTRUCTION-1 -: NB_OPCODE] == '0);

    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_addr;
        w_hi_nxt         = r_hi;
        w_wr_address_nxt = r_wr_address;
        w_wr_data_nxt    = r_wr_data;
        w_wr_enb_nxt     = 1'b0;
        w_cpu_reset_nxt  = r_cpu_reset;
        w_load_done_nxt  = r_load_done;
        w_error_nxt      = r_error;

        case (r_state)
            S_WAIT_HI: begin
                if (io_bus.i_rx_valid) begin
                    w_hi_nxt    = io_bus.i_rx_data;
                    w_state_nxt = S_WAIT_LO;
                end
            end

            S_WAIT_LO: begin
                if (io_bus.i_rx_valid) begin
                    w_wr_data_nxt    = {r_hi, io_bus.i_rx_data};
                    w_wr_address_nxt = r_addr;
                    w_wr_enb_nxt     = 1'b1;
                    w_state_nxt      = S_WRITE;
                end
            end

            S_WRITE: begin
                if (w_is_halt) begin
                    w_cpu_reset_nxt = 1'b0;
                    w_load_done_nxt = 1'b1;
                    w_state_nxt     = S_DONE;
                end else if (r_addr == ADDR_LAST) begin
                    // Counter saturates here; never wraps back to 0.
                    w_error_nxt = 1'b1;
                    w_state_nxt = S_ERROR;
                end else begin
                    w_addr_nxt = r_addr + 1'b1;
                    // A byte arriving during the write slot is the next
                    // high byte, so back-to-back streams lose nothing.
                    if (io_bus.i_rx_valid) begin
                        w_hi_nxt    = io_bus.i_rx_data;
                        w_state_nxt = S_WAIT_LO;
                    end else begin
                        w_state_nxt = S_WAIT_HI;
                    end
                end
            end

            S_DONE, S_ERROR: begin
                // Bytes are ignored here; a restart request wins over a
                // byte strobe in the same cycle and the byte is dropped.
                if (i_load_req) begin
                    w_addr_nxt      = '0;
                    w_load_done_nxt = 1'b0;
                    w_error_nxt     = 1'b0;
                    w_cpu_reset_nxt = 1'b1;
                    w_state_nxt     = S_WAIT_HI;
                end
            end

            default: begin
                w_state_nxt = S_WAIT_HI;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= S_WAIT_HI;
            r_addr       <= '0;
            r_hi         <= '0;
            r_wr_address <= '0;
            r_wr_data    <= '0;
            r_wr_enb     <= 1'b0;
            r_cpu_reset  <= 1'b1;
            r_load_done  <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_addr       <= w_addr_nxt;
            r_hi         <= w_hi_nxt;
            r_wr_address <= w_wr_address_nxt;
            r_wr_data    <= w_wr_data_nxt;
            r_wr_enb     <= w_wr_enb_nxt;
            r_cpu_reset  <= w_cpu_reset_nxt;
            r_load_done  <= w_load_done_nxt;
            r_error      <= w_error_nxt;
        end
    end

    assign io_bus.o_wr_address = r_wr_address;
    assign io_bus.o_wr_data    = r_wr_data;
    assign io_bus.o_wr_enb     = r_wr_enb;
    assign o_cpu_reset         = r_cpu_reset;
    assign o_load_done         = r_load_done;
    assign o_error             = r_error;

endmodule
